cpu_step_ctrl: RTL
==================

Name: cpu_step_ctrl

Overview:
Board-level CPU clock-enable controller for the MIPS SoC FPGA top. Synchronises and debounces NUM_BTN push-buttons. Produces a one-cycle cpu_ce pulse under three modes: HALT, single STEP, or free RUN at a selectable rate. The CPU runs on the 100 MHz board clock gated by cpu_ce, replacing a debounced button used directly as the CPU clock.

Parameters:
NUM_BTN, 4, number of push-button inputs (min 2)
DB_CYCLES, 500000, consecutive stable cycles required to accept a button level change (min 2)
RUN_DIV_BASE, 25000000, cpu_ce period in RUN mode at rate_sel=0 (min 1)
COUNT_W, 16, width of step_count
STEP_BTN, 0, button index that issues a single step
MODE_BTN, 1, button index that cycles the mode

Ports:
clk  in  1  board clock
rst_n  in  1  reset, asynchronous assert, active-low
btn_raw  in  NUM_BTN  raw asynchronous button pins
rate_sel  in  2  RUN rate; divisor = RUN_DIV_BASE << (2*rate_sel)
halt_req  in  1  level request from SoC GPO forcing HALT
btn_level  out  NUM_BTN  debounced button levels
btn_press  out  NUM_BTN  one-cycle pulse on each debounced rising edge
cpu_ce  out  1  one-cycle CPU clock enable
mode  out  2  0=HALT, 1=STEP, 2=RUN (3 never produced)
step_count  out  COUNT_W  count of cpu_ce pulses since reset

Behaviour:
- Reset (rst_n=0, asynchronous): sync flops, debounce counters, btn_level, btn_press, cpu_ce, run divider, step_count = 0; mode = HALT. Release is used directly; the board top supplies a synchronised rst_n.
- Synchroniser: 2-flop per button; sync output lags btn_raw by 2 cycles.
- Debounce, per button:
  - sync != btn_level: counter increments.
  - sync == btn_level: counter clears.
  - On the edge where the counter would reach DB_CYCLES: btn_level toggles and the counter clears.
  - Glitches shorter than DB_CYCLES are rejected.
  - Raw-to-level latency is 2+DB_CYCLES cycles.
- btn_press[i]: high for exactly the cycle in which btn_level[i] first reads 1. No pulse on release.
- Mode FSM (registered), evaluated on each edge:
  - halt_req=1: next mode = HALT; MODE_BTN presses ignored.
  - Otherwise, btn_press[MODE_BTN]: HALT->STEP->RUN->HALT.
  - Mode change takes effect the cycle after the press.
- cpu_ce (registered, one cycle wide):
  - STEP: asserted the cycle after btn_press[STEP_BTN], only if the mode register is STEP that cycle and neither btn_press[MODE_BTN] nor halt_req is asserted. Mode press wins over step press in the same cycle.
  - RUN: divider counts 0..div-1. cpu_ce asserts on the cycle the divider wraps to 0, giving period exactly div cycles.
  - Entering RUN: divider cleared; first cpu_ce occurs div cycles after mode reads RUN.
  - rate_sel changes in RUN: new divisor applies immediately. If the counter is >= the new div-1, it wraps on the next edge and produces one cpu_ce.
  - HALT, or halt_req=1: cpu_ce=0 from the next cycle. A cpu_ce already registered still completes its single cycle.
  - Step presses in RUN or HALT are ignored.
- step_count: increments by 1 on every cycle with cpu_ce=1. Wraps modulo 2^COUNT_W.
- Divider width: 32 bits. RUN_DIV_BASE<<6 must fit in 32 bits; elaboration error otherwise.

Decomposition:
- Package cpu_step_pkg: mode_e enum (MODE_HALT=2'd0, MODE_STEP=2'd1, MODE_RUN=2'd2) and DIV_W=32.
- Sub-module btn_debounce: one synchroniser + counter + level + press per button, instantiated NUM_BTN times via generate.
- FSM, divider and step_count live in cpu_step_ctrl.

Test Plan:
All tests use DB_CYCLES=4, RUN_DIV_BASE=3.
1. Hold rst_n=0, then release. Check all outputs 0 and mode=0. Assert rst_n=0 mid-RUN: outputs clear asynchronously, without waiting for a clock edge.
2. Bounce btn_raw[0] 1-0-1 with 2-cycle pulses, then hold high 10 cycles. Required: no btn_press during the bounce; btn_level[0] rises exactly 6 cycles after the final rising edge; one btn_press[0] pulse.
3. Press MODE three times. Required: mode 0->1->2->0. In mode 1, one STEP press gives exactly one cpu_ce and step_count=1.
4. RUN with rate_sel=0: cpu_ce every 3 cycles, first pulse 3 cycles after mode=2. Switch to rate_sel=1: period becomes 12 cycles.
5. halt_req=1 during RUN: mode=0 next cycle, no further cpu_ce. MODE presses while halt_req=1 leave mode=0.
6. In STEP, press STEP and MODE debounced in the same cycle: mode becomes 2 and no cpu_ce is issued. Force step_count to 16'hFFFF via 65535 steps; the next step gives step_count=0.

Source files
------------

// File: rtl/cpu_step_pkg.sv
// Shared types for the CPU clock-enable controller.
package cpu_step_pkg;

   localparam int unsigned DIV_W = 32;

   typedef enum logic [1:0] {
      MODE_HALT = 2'd0,
      MODE_STEP = 2'd1,
      MODE_RUN  = 2'd2
   } mode_e;

   // Mode button advances HALT -> STEP -> RUN -> HALT.
   function automatic mode_e next_mode(input mode_e m);
      case (m)
         MODE_HALT: return MODE_STEP;
         MODE_STEP: return MODE_RUN;
         default:   return MODE_HALT;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, stability counter, debounced level and press pulse.
module btn_debounce #(
   parameter int unsigned DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press
);

   localparam int unsigned CNT_W = $clog2(DB_CYCLES);

   logic             meta_q, sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q;

   // Counter only runs while the synced input disagrees with the accepted level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync_q != level_q) begin
         if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         meta_q  <= btn_raw;
         sync_q  <= meta_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= level_d & ~level_q;
      end
   end

   assign btn_level = level_q;
   assign btn_press = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable controller: debounced buttons drive a HALT/STEP/RUN mode FSM
// that issues single-cycle cpu_ce pulses and counts them.
module cpu_step_ctrl
   import cpu_step_pkg::*;
#(
   parameter int unsigned NUM_BTN      = 4,
   parameter int unsigned DB_CYCLES    = 500000,
   parameter int unsigned RUN_DIV_BASE = 25000000,
   parameter int unsigned COUNT_W      = 16,
   parameter int unsigned STEP_BTN     = 0,
   parameter int unsigned MODE_BTN     = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic [1:0]         rate_sel,
   input  logic               halt_req,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic               cpu_ce,
   output logic [1:0]         mode,
   output logic [COUNT_W-1:0] step_count
);

   localparam longint unsigned MAX_BASE = ((64'd1 << DIV_W) - 64'd1) >> 6;

   if (longint'(RUN_DIV_BASE) > MAX_BASE || RUN_DIV_BASE < 1) begin : g_bad_div
      $error("RUN_DIV_BASE << 6 must fit the 32-bit divider");
   end
   if (NUM_BTN < 2 || DB_CYCLES < 2 || STEP_BTN >= NUM_BTN || MODE_BTN >= NUM_BTN)
   begin : g_bad_btn
      $error("invalid button configuration");
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DB_CYCLES(DB_CYCLES)
      ) u_db (
         .clk      (clk),
         .rst_n    (rst_n),
         .btn_raw  (btn_raw[i]),
         .btn_level(btn_level[i]),
         .btn_press(btn_press[i])
      );
   end

   mode_e              mode_q, mode_d;
   logic [DIV_W-1:0]   div_q, div_d, div_last;
   logic               ce_q, ce_d;
   logic [COUNT_W-1:0] count_q;
   logic               step_press, mode_press;

   assign step_press = btn_press[STEP_BTN];
   assign mode_press = btn_press[MODE_BTN];
   assign div_last   = (DIV_W'(RUN_DIV_BASE) << {rate_sel, 1'b0}) - 1'b1;

   always_comb begin
      mode_d = mode_q;
      if (halt_req) begin
         mode_d = MODE_HALT;
      end else if (mode_press) begin
         mode_d = next_mode(mode_q);
      end
   end

   // Divider stays cleared outside RUN so each entry starts a full period.
   // Using >= lets a shrinking rate_sel wrap at once instead of overrunning.
   always_comb begin
      div_d = '0;
      ce_d  = 1'b0;
      case (mode_q)
         MODE_STEP: ce_d = step_press & ~mode_press & ~halt_req;
         MODE_RUN: begin
            if (div_q >= div_last) begin
               ce_d = ~halt_req;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= MODE_HALT;
         div_q   <= '0;
         ce_q    <= 1'b0;
         count_q <= '0;
      end else begin
         mode_q <= mode_d;
         div_q  <= div_d;
         ce_q   <= ce_d;
         if (ce_q) begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   assign cpu_ce     = ce_q;
   assign mode       = mode_q;
   assign step_count = count_q;

endmodule
